psum_row_buf: RTL and testbench
===============================

PSUM_ROW_BUF -- requirements
Module: psum_row_buf

Interface
REQ-001 Parameter PSUM_WIDTH, default 24, width in bits of one signed two's-complement partial sum.
REQ-002 Parameter LENPSUM, default 16, number of partial-sum entries per bank (one convolution output row).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous flush of both banks and all pointers.
REQ-006 in_vld  input  1  partial sum present on in_psum (driven by the row convolution's accumulate pulse).
REQ-007 in_psum  input  PSUM_WIDTH  partial sum from the row convolution output.
REQ-008 in_last  input  1  qualified by in_vld; marks the final partial sum of the row.
REQ-009 in_rdy  output  1  fill bank can accept a word this cycle.
REQ-010 out_vld  output  1  drain word valid.
REQ-011 out_rdy  input  1  downstream accepts the drain word.
REQ-012 out_data  output  PSUM_WIDTH  drain word.
REQ-013 out_last  output  1  qualified by out_vld; final word of the bank being drained.
REQ-014 err_drop  output  1  sticky flag: a word was presented while in_rdy=0.

Function
REQ-015 The block SHALL hold two banks (0, 1), each LENPSUM x PSUM_WIDTH, plus a per-bank full flag and a per-bank word count (1..LENPSUM).
REQ-016 Write: when in_vld=1 and in_rdy=1, in_psum SHALL be stored at wr_addr of the fill bank, and wr_addr SHALL increment.
REQ-017 The fill bank SHALL close on the accepted write carrying in_last=1, or on the accepted write at wr_addr=LENPSUM-1, whichever comes first. On close, the count SHALL be latched as wr_addr+1, full SHALL be set, wr_addr SHALL return to 0, and the fill pointer SHALL toggle.
REQ-018 in_rdy SHALL be 1 exactly when the bank selected by the fill pointer is not full; the value is registered state, with no combinational path from in_vld or out_rdy.
REQ-019 Drain: out_vld SHALL be 1 exactly when the bank selected by the drain pointer is full. out_data SHALL be that bank's entry at rd_addr, combinationally muxed.
REQ-020 On out_vld=1 and out_rdy=1, rd_addr SHALL increment. out_last SHALL be 1 when rd_addr=count-1. On the last handshake, the bank's full flag SHALL clear, rd_addr SHALL return to 0, and the drain pointer SHALL toggle.
REQ-021 Banks SHALL drain in strict fill order; out_data and out_last SHALL hold stable while out_vld=1 and out_rdy=0.
REQ-022 Latency: for a bank closed at cycle N with the drain side idle, out_vld SHALL first be 1 at cycle N+1.
REQ-023 Simultaneous close of the fill bank and release of the drain bank in the same cycle: both updates SHALL take effect. in_rdy SHALL be 1 and out_vld SHALL be 1 in cycle N+1, with no lost word.
REQ-024 in_vld=1 while in_rdy=0: the word SHALL be discarded, no state SHALL change, and err_drop SHALL set, remaining set until reset or clr.
REQ-025 clr SHALL have priority over all writes and drains in the same cycle. It SHALL clear full flags, pointers, addresses and err_drop; bank contents are don't-care.
REQ-026 in_last with in_vld=0 SHALL be ignored.

Reset
REQ-027 Asynchronous reset SHALL force in_rdy=1, out_vld=0, out_last=0, out_data=0 and err_drop=0. It SHALL also zero all pointers, addresses, counts and full flags.
REQ-028 Reset asserted mid-row or mid-drain SHALL abandon all buffered data; the first accepted word after reset SHALL be written to bank 0, address 0.

Configuration
REQ-029 Macro PSUMBUF_RELU_EN defined: out_data SHALL be 0 whenever the selected entry is negative, and the entry otherwise; stored values stay unmodified.
REQ-030 Macro PSUMBUF_RELU_EN undefined: out_data SHALL equal the stored entry bit-exactly.

Verification
REQ-031 Full row: LENPSUM=16; write values 1..16 back-to-back with out_rdy=1 -> out_vld rises the cycle after the 16th write; drain yields 1..16 with out_last on 16.
REQ-032 Short row: 5 writes, in_last on the 5th -> drain yields 5 words with out_last on the 5th; the next write lands in bank 1, address 0.
REQ-033 Backpressure: out_rdy=0 and 40 writes offered -> first 32 accepted, in_rdy=0 after the 32nd, err_drop=1 after the 33rd; then out_rdy=1 drains 32 words in order.
REQ-034 Simultaneous close/release: drain's last handshake coincides with the 16th write into the other bank -> next cycle in_rdy=1, out_vld=1, out_data equals the first word of the just-closed bank.
REQ-035 ReLU: write -7, 3 (PSUMBUF_RELU_EN defined) -> drain 0, 3; macro undefined -> -7, 3.
REQ-036 Reset/clr mid-drain after 3 of 16 words -> out_vld=0, in_rdy=1, err_drop=0; the next row drains only new data.

Source files
------------

// File: rtl/psum_row_buf.sv
// Double-buffered partial-sum row buffer: one bank fills from the row convolution while the other drains downstream.
// Optional build macro PSUMBUF_RELU_EN clamps negative drain words to zero on the output path only.
module psum_row_buf #(
   parameter int PSUM_WIDTH = 24,
   parameter int LENPSUM    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_vld,
   input  logic [PSUM_WIDTH-1:0] in_psum,
   input  logic                  in_last,
   output logic                  in_rdy,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [PSUM_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  err_drop
);

   localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
   localparam int CW = $clog2(LENPSUM + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(LENPSUM - 1);

   logic [PSUM_WIDTH-1:0] mem_q [2][LENPSUM];

   logic [1:0]         full_q,      full_d;
   logic [1:0][CW-1:0] cnt_q,       cnt_d;
   logic [AW-1:0]      wr_addr_q,   wr_addr_d;
   logic [AW-1:0]      rd_addr_q,   rd_addr_d;
   logic               fill_ptr_q,  fill_ptr_d;
   logic               drain_ptr_q, drain_ptr_d;
   logic               err_q,       err_d;

   logic                  wr_fire;
   logic                  wr_close;
   logic                  rd_fire;
   logic                  rd_release;
   logic                  mem_we;
   logic [PSUM_WIDTH-1:0] rd_entry;

   // Handshake flags come straight from flops, so neither ready nor valid depends on the other side's inputs.
   assign in_rdy   = ~full_q[fill_ptr_q];
   assign out_vld  = full_q[drain_ptr_q];
   assign out_last = out_vld && ((CW'(rd_addr_q) + CW'(1)) == cnt_q[drain_ptr_q]);
   assign err_drop = err_q;

   assign wr_fire    = in_vld & in_rdy;
   assign wr_close   = wr_fire & (in_last | (wr_addr_q == LAST_ADDR));
   assign rd_fire    = out_vld & out_rdy;
   assign rd_release = rd_fire & out_last;
   assign mem_we     = wr_fire & ~clr;

   assign rd_entry = mem_q[drain_ptr_q][rd_addr_q];

   // Idle drain port presents zero so the output is defined even though bank contents are not reset.
   always_comb begin
      out_data = '0;
      if (out_vld) begin
`ifdef PSUMBUF_RELU_EN
         out_data = rd_entry[PSUM_WIDTH-1] ? '0 : rd_entry;
`else
         out_data = rd_entry;
`endif
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets its hold value first; a path that skips an assignment would infer a latch.
      full_d      = full_q;
      cnt_d       = cnt_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      fill_ptr_d  = fill_ptr_q;
      drain_ptr_d = drain_ptr_q;
      err_d       = err_q;

      if (clr) begin
         full_d      = '0;
         wr_addr_d   = '0;
         rd_addr_d   = '0;
         fill_ptr_d  = 1'b0;
         drain_ptr_d = 1'b0;
         err_d       = 1'b0;
      end else begin
         if (in_vld && !in_rdy) begin
            err_d = 1'b1;
         end

         if (wr_fire) begin
            if (wr_close) begin
               cnt_d[fill_ptr_q]  = CW'(wr_addr_q) + CW'(1);
               full_d[fill_ptr_q] = 1'b1;
               wr_addr_d          = '0;
               fill_ptr_d         = ~fill_ptr_q;
            end else begin
               wr_addr_d = wr_addr_q + AW'(1);
            end
         end

         // Close and release always touch different banks, so both updates can land in one cycle.
         if (rd_fire) begin
            if (rd_release) begin
               full_d[drain_ptr_q] = 1'b0;
               rd_addr_d           = '0;
               drain_ptr_d         = ~drain_ptr_q;
            end else begin
               rd_addr_d = rd_addr_q + AW'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q      <= '0;
         cnt_q       <= '0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         fill_ptr_q  <= 1'b0;
         drain_ptr_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         full_q      <= full_d;
         cnt_q       <= cnt_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         fill_ptr_q  <= fill_ptr_d;
         drain_ptr_q <= drain_ptr_d;
         err_q       <= err_d;
      end
   end

   // NOTE: bank storage has no reset; full flags gate every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[fill_ptr_q][wr_addr_q] <= in_psum;
      end
   end

endmodule

// File: tb/tb_psum_row_buf.sv
// Directed bench for psum_row_buf: a scoreboard queue is loaded as words are written and checked on each drain handshake.
// Honours PSUMBUF_RELU_EN the same way the design does when forming expected drain words.
module tb_psum_row_buf;

   localparam int PSUM_WIDTH = 24;
   localparam int LENPSUM    = 16;

   typedef struct packed {
      logic [PSUM_WIDTH-1:0] data;
      logic                  last;
   } sb_t;

   logic                  clk;
   logic                  rst_n;
   logic                  clr;
   logic                  in_vld;
   logic [PSUM_WIDTH-1:0] in_psum;
   logic                  in_last;
   logic                  in_rdy;
   logic                  out_vld;
   logic                  out_rdy;
   logic [PSUM_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  err_drop;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  wr_cnt  = 0;
   sb_t sb[$];

   psum_row_buf #(.PSUM_WIDTH(PSUM_WIDTH), .LENPSUM(LENPSUM)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_vld   (in_vld),
      .in_psum  (in_psum),
      .in_last  (in_last),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_last (out_last),
      .err_drop (err_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PSUM_WIDTH-1:0] model_out(input logic [PSUM_WIDTH-1:0] v);
`ifdef PSUMBUF_RELU_EN
      return v[PSUM_WIDTH-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word that the bench expects to be accepted; its expected drain image goes on the scoreboard.
   task automatic push_write(input logic [PSUM_WIDTH-1:0] v, input logic last);
      sb_t e;
      e.data = model_out(v);
      e.last = last || (wr_cnt == LENPSUM - 1);
      sb.push_back(e);
      wr_cnt  = e.last ? 0 : wr_cnt + 1;
      in_vld  = 1'b1;
      in_psum = v;
      in_last = last;
      step();
      in_vld  = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drop_write(input logic [PSUM_WIDTH-1:0] v);
      in_vld  = 1'b1;
      in_psum = v;
      step();
      in_vld  = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      out_rdy = 1'b1;
      while (sb.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_done", sb.size(), 0);
      check("idle_after_drain", out_vld, 1'b0);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      sb.delete();
      wr_cnt = 0;
   endtask

   // Outputs sampled on the falling edge: a handshake seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && !clr && out_vld && out_rdy) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_out: observed data %0h with empty scoreboard", out_data);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("drain_data", out_data, e.data);
            check("drain_last", out_last, e.last);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      in_vld  = 1'b0;
      in_psum = '0;
      in_last = 1'b0;
      out_rdy = 1'b0;
      #2;
      check("rst_in_rdy",   in_rdy,   1'b1);
      check("rst_out_vld",  out_vld,  1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 0);
      check("rst_err_drop", err_drop, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // Full row: 1..16 back-to-back, valid rises the cycle after the closing write.
      out_rdy = 1'b1;
      for (int i = 1; i <= LENPSUM; i++) begin
         push_write(PSUM_WIDTH'(i), 1'b0);
         if (i == LENPSUM - 1) check("full_no_early_vld", out_vld, 1'b0);
      end
      check("full_vld_latency", out_vld, 1'b1);
      check("full_first_data",  out_data, 1);
      wait_drain(40);

      // Short row closed by in_last, then a second row in the other bank.
      do_clr();
      in_vld  = 1'b0;
      in_last = 1'b1;
      step();
      in_last = 1'b0;
      check("stray_last_ignored", out_vld, 1'b0);
      for (int i = 0; i < 5; i++) push_write(PSUM_WIDTH'(100 + i), i == 4);
      check("short_vld", out_vld, 1'b1);
      wait_drain(20);
      push_write(PSUM_WIDTH'(150), 1'b0);
      push_write(PSUM_WIDTH'(151), 1'b1);
      wait_drain(20);

      // Backpressure: both banks fill, extra words drop and set the sticky flag.
      do_clr();
      out_rdy = 1'b0;
      for (int i = 0; i < 2 * LENPSUM; i++) push_write(PSUM_WIDTH'(32'h200 + i), 1'b0);
      check("bp_in_rdy_low", in_rdy,   1'b0);
      check("bp_no_err_yet", err_drop, 1'b0);
      drop_write(PSUM_WIDTH'(32'h2ff));
      check("bp_err_set", err_drop, 1'b1);
      for (int i = 0; i < 7; i++) drop_write(PSUM_WIDTH'(32'h2f0 + i));
      for (int i = 0; i < 3; i++) begin
         check("bp_hold_data", out_data, 32'h200);
         check("bp_hold_last", out_last, 1'b0);
         step();
      end
      wait_drain(80);
      check("bp_err_sticky", err_drop, 1'b1);
      do_clr();
      check("clr_err", err_drop, 1'b0);

      // Drain's final handshake lands in the same cycle as the other bank's closing write.
      out_rdy = 1'b0;
      for (int i = 0; i < LENPSUM; i++) push_write(PSUM_WIDTH'(32'h500 + i), 1'b0);
      for (int i = 0; i < LENPSUM - 1; i++) push_write(PSUM_WIDTH'(32'h600 + i), 1'b0);
      out_rdy = 1'b1;
      for (int i = 0; i < LENPSUM - 1; i++) step();
      push_write(PSUM_WIDTH'(32'h600 + LENPSUM - 1), 1'b0);
      check("sim_in_rdy",   in_rdy,   1'b1);
      check("sim_out_vld",  out_vld,  1'b1);
      check("sim_out_data", out_data, 32'h600);
      wait_drain(40);

      // Negative and positive words through the optional clamp.
      do_clr();
      out_rdy = 1'b0;
      push_write(-PSUM_WIDTH'(7), 1'b0);
      push_write(PSUM_WIDTH'(3), 1'b1);
`ifdef PSUMBUF_RELU_EN
      check("relu_head", out_data, 0);
`else
      check("relu_head", out_data, 32'hfffff9);
`endif
      wait_drain(10);

      // Reset mid-drain abandons the buffered row.
      out_rdy = 1'b0;
      for (int i = 0; i < LENPSUM; i++) push_write(PSUM_WIDTH'(32'h300 + i), 1'b0);
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_rdy = 1'b0;
      rst_n   = 1'b0;
      sb.delete();
      wr_cnt  = 0;
      #2;
      check("rst_mid_vld",   out_vld,  1'b0);
      check("rst_mid_rdy",   in_rdy,   1'b1);
      check("rst_mid_err",   err_drop, 1'b0);
      check("rst_mid_data",  out_data, 0);
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) push_write(PSUM_WIDTH'(32'h400 + i), i == 3);
      wait_drain(20);

      // Same scenario abandoned with the synchronous flush instead.
      out_rdy = 1'b0;
      for (int i = 0; i < LENPSUM; i++) push_write(PSUM_WIDTH'(32'h700 + i), 1'b0);
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_rdy = 1'b0;
      do_clr();
      check("clr_mid_vld", out_vld,  1'b0);
      check("clr_mid_rdy", in_rdy,   1'b1);
      check("clr_mid_err", err_drop, 1'b0);
      for (int i = 0; i < 4; i++) push_write(PSUM_WIDTH'(32'h800 + i), i == 3);
      check("clr_new_head", out_data, 32'h800);
      wait_drain(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
